// File: rtl/decoder_nx_seq.sv
// decoder_nx_seq: registered N-to-2^N decoder with a valid handshake,
// a thermometer mode and a free-running walking-one scan sequencer.
// Every output comes straight from a flop. ACT_LOW flips the polarity
// of the whole dout bus.
module decoder_nx_seq #(
  parameter int unsigned N        = 3,
  parameter int unsigned SCAN_DIV = 4,
  parameter bit          ACT_LOW  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [N-1:0]          din,
  input  logic                  din_valid,
  output logic [(2**N)-1:0]     dout,
  output logic                  dout_valid,
  output logic                  scan_wrap
);

  localparam int unsigned OUT_W = 2 ** N;
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [N-1:0]     IDX_LAST = N'(OUT_W - 1);

  // XOR mask applied to every raw pattern; all ones inverts for active-low
  localparam logic [OUT_W-1:0] INACTIVE = {OUT_W{ACT_LOW}};

  // Operating modes, also used as the prev_mode state encoding
  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_THERM  = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  logic [OUT_W-1:0] dout_q,       dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             scan_wrap_q,  scan_wrap_d;
  logic [N-1:0]     scan_idx_q,   scan_idx_d;
  logic [DIV_W-1:0] div_cnt_q,    div_cnt_d;
  logic [1:0]       prev_mode_q,  prev_mode_d;

  logic             scan_entry_c;
  logic             scan_step_c;

  // One-hot pattern: only bit k set
  function automatic logic [OUT_W-1:0] onehot_pat(input logic [N-1:0] k);
    logic [OUT_W-1:0] p;
    p    = '0;
    p[k] = 1'b1;
    return p;
  endfunction

  // Thermometer pattern: bits 0..k set
  function automatic logic [OUT_W-1:0] therm_pat(input logic [N-1:0] k);
    logic [OUT_W-1:0] p;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      p[i] = (i <= 32'(k));
    end
    return p;
  endfunction

  // Scan entry is detected against the mode seen at the last enabled edge
  always_comb begin
    scan_entry_c = (mode == MODE_SCAN) && (prev_mode_q != MODE_SCAN);
    scan_step_c  = (div_cnt_q == DIV_LAST);
  end

  // Next-state and output decode
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    scan_wrap_d  = 1'b0;
    scan_idx_d   = scan_idx_q;
    div_cnt_d    = div_cnt_q;
    prev_mode_d  = prev_mode_q;

    if (en) begin
      prev_mode_d = mode;
      case (mode)
        MODE_DIRECT: begin
          if (din_valid) begin
            dout_d       = onehot_pat(din) ^ INACTIVE;
            dout_valid_d = 1'b1;
          end
        end
        MODE_THERM: begin
          if (din_valid) begin
            dout_d       = therm_pat(din) ^ INACTIVE;
            dout_valid_d = 1'b1;
          end
        end
        MODE_SCAN: begin
          if (scan_entry_c) begin
            // Restart the walk; first step lands SCAN_DIV edges later
            div_cnt_d  = '0;
            scan_idx_d = '0;
          end else if (scan_step_c) begin
            div_cnt_d    = '0;
            dout_d       = onehot_pat(scan_idx_q) ^ INACTIVE;
            dout_valid_d = 1'b1;
            scan_wrap_d  = (scan_idx_q == IDX_LAST);
            scan_idx_d   = scan_idx_q + N'(1);
          end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
          end
        end
        default: begin
          // HOLD: nothing moves, no pulses
        end
      endcase
    end
  end

  // State register with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q       <= INACTIVE;
      dout_valid_q <= 1'b0;
      scan_wrap_q  <= 1'b0;
      scan_idx_q   <= '0;
      div_cnt_q    <= '0;
      prev_mode_q  <= MODE_HOLD;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      scan_wrap_q  <= scan_wrap_d;
      scan_idx_q   <= scan_idx_d;
      div_cnt_q    <= div_cnt_d;
      prev_mode_q  <= prev_mode_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign scan_wrap  = scan_wrap_q;

endmodule
